// File: rtl/bcd16_to_bin12_if.sv
// Bus bundle for the BCD-to-binary converter: start request and packed BCD in,
// registered binary result with completion/error/busy status out.
interface bcd16_to_bin12_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 12
);
  logic                  en;
  logic [4*DIGITS-1:0]   bcd_d_in;
  logic [OUT_W-1:0]      bin_d_out;
  logic                  rdy;
  logic                  err;
  logic                  busy;

  modport master (
    output en, bcd_d_in,
    input  bin_d_out, rdy, err, busy
  );

  modport slave (
    input  en, bcd_d_in,
    output bin_d_out, rdy, err, busy
  );
endinterface

// File: rtl/bcd16_to_bin12.sv
// Digit-serial packed-BCD to binary converter: acc = acc*10 + digit, MSD first,
// one digit per clock, with sticky invalid-digit detection and output saturation.
module bcd16_to_bin12 #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd16_to_bin12_if.slave   bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int ACC_W = $clog2(10 ** DIGITS);
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_reg, state_next;
  logic [SR_W-1:0]    sr_reg, sr_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               inv_reg, inv_next;
  logic [OUT_W-1:0]   out_reg, out_next;
  logic               rdy_reg, rdy_next;
  logic               err_reg, err_next;

  logic [3:0]         nib;
  logic [ACC_W-1:0]   acc_mac;
  logic               inv_mac;
  logic               ovf;

  assign nib     = sr_reg[SR_W-1 -: 4];
  assign acc_mac = acc_reg * ACC_W'(10) + ACC_W'(nib);
  assign inv_mac = inv_reg | (nib > 4'd9);
  // Both sides widened to ACC_W+OUT_W so the compare is valid for any parameter mix.
  assign ovf     = ({{OUT_W{1'b0}}, acc_mac} > {{ACC_W{1'b0}}, {OUT_W{1'b1}}});

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    inv_next   = inv_reg;
    out_next   = out_reg;
    err_next   = err_reg;
    rdy_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          state_next = CONV;
          sr_next    = bus.bcd_d_in;
          acc_next   = '0;
          cnt_next   = '0;
          inv_next   = 1'b0;
        end
      end
      CONV: begin
        sr_next  = sr_reg << 4;
        acc_next = acc_mac;
        inv_next = inv_mac;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DIGITS - 1)) begin
          state_next = IDLE;
          rdy_next   = 1'b1;
          // An invalid digit makes the magnitude meaningless, so it wins over saturation.
          if (inv_mac) begin
            out_next = '0;
            err_next = 1'b1;
          end else if (ovf) begin
            out_next = '1;
            err_next = 1'b1;
          end else begin
            out_next = OUT_W'(acc_mac);
            err_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      inv_reg   <= 1'b0;
      out_reg   <= '0;
      rdy_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      inv_reg   <= inv_next;
      out_reg   <= out_next;
      rdy_reg   <= rdy_next;
      err_reg   <= err_next;
    end
  end

  assign bus.bin_d_out = out_reg;
  assign bus.rdy       = rdy_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = (state_reg == CONV);

endmodule

// File: tb/tb_bcd16_to_bin12.sv
// Scoreboard bench for bcd16_to_bin12: a capture model pushes expected results,
// a negedge monitor pops and compares on every rdy pulse.
module tb_bcd16_to_bin12;

  localparam int DIGITS = 4;
  localparam int OUT_W  = 12;

  typedef struct {
    logic [OUT_W-1:0] val;
    logic             err;
    int               due;
    logic [15:0]      bcd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  bcd16_to_bin12_if #(.DIGITS(DIGITS), .OUT_W(OUT_W)) bus ();

  bcd16_to_bin12 #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  // Decimal meaning of the packed digits, straight from the rules.
  function automatic exp_t ref_model(input logic [15:0] b, input int due);
    exp_t r;
    int   value = 0;
    bit   bad   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      int d;
      d = int'((b >> (4 * k)) & 16'hF);
      if (d > 9) bad = 1'b1;
      value += d * (10 ** k);
    end
    r.bcd = b;
    r.due = due;
    if (bad) begin
      r.val = '0;
      r.err = 1'b1;
    end else if (value > (2 ** OUT_W) - 1) begin
      r.val = '1;
      r.err = 1'b1;
    end else begin
      r.val = OUT_W'(value);
      r.err = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] b;
    b = '0;
    for (int k = 0; k < DIGITS; k++)
      b[4*k +: 4] = 4'((v / (10 ** k)) % 10);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Capture model: a conversion starts when en is seen while the model is idle.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (bus.en) begin
      sb.push_back(ref_model(bus.bcd_d_in, cyc + DIGITS));
      busy_cnt = DIGITS;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(busy_cnt > 0));
    if (bus.rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got rdy=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn bcd=%04h bin=%03h err=%0d exp_bin=%03h exp_err=%0d", e.bcd, bus.bin_d_out, bus.err, e.val, e.err);
        chk("rdy_cycle", 32'(cyc), 32'(e.due));
        chk("bin_d_out", 32'(bus.bin_d_out), 32'(e.val));
        chk("err", 32'(bus.err), 32'(e.err));
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_rdy: got rdy=0 expected rdy for bcd=%04h (cycle %0d)", sb[0].bcd, cyc);
      void'(sb.pop_front());
    end
  end

  // Called at a negedge; mode 0 drops en after capture, 1 holds en/bcd, 2 scrambles them.
  task automatic issue(input logic [15:0] v, input int mode);
    int guard = 0;
    while (busy_cnt != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: got busy after %0d cycles expected idle", guard);
    end
    bus.en       = 1'b1;
    bus.bcd_d_in = v;
    @(negedge clk);
    if (mode == 0) begin
      bus.en = 1'b0;
    end else if (mode == 2) begin
      bus.en       = 1'($urandom);
      bus.bcd_d_in = 16'($urandom);
    end
  endtask

  task automatic drain();
    int guard = 0;
    bus.en = 1'b0;
    while ((sb.size() > 0 || busy_cnt > 0) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (guard >= 30) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  logic [15:0] directed [7] = '{16'h0255, 16'h4095, 16'h4096, 16'h9999,
                                16'h0000, 16'h12A4, 16'hF999};

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.bcd_d_in = 16'h0255;
    repeat (3) @(negedge clk);
    chk("reset_bin", 32'(bus.bin_d_out), 32'h0);
    chk("reset_rdy", 32'(bus.rdy), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    foreach (directed[i]) issue(directed[i], 0);
    drain();

    // en held high: captures five cycles apart
    issue(16'h0001, 1);
    issue(16'h0010, 1);
    drain();

    // abort 1234 in its second CONV cycle after a non-zero result is on the output
    issue(16'h4095, 0);
    drain();
    issue(16'h1234, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_bin", 32'(bus.bin_d_out), 32'h0);
    chk("abort_rdy", 32'(bus.rdy), 32'h0);
    chk("abort_err", 32'(bus.err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_rdy", 32'(bus.rdy), 32'h0);
    issue(16'h1234, 0);
    drain();

    repeat (150) issue(16'($urandom), 2);
    repeat (150) issue(bin2bcd(int'($urandom_range(0, 9999))), 0);
    drain();

    for (int v = 0; v < 4096; v++) issue(bin2bcd(v), (v % 3 == 0) ? 2 : 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
